// File: rtl/perf_counter_pkg.sv
// Shared defaults and output-FSM state encoding for the event counter sampler.
package perf_counter_pkg;

  localparam int DEF_NUM_EVENTS    = 115;
  localparam int DEF_COUNTER_WIDTH = 7;
  localparam int DEF_WINDOW_WIDTH  = 16;

  // Snapshot holding register state: EMPTY has nothing for the consumer,
  // FULL presents a snapshot with out_valid high.
  typedef enum logic [0:0] {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/event_counter_sampler_if.sv
// Snapshot output bus: valid/ready handshake plus the snapshot payload.
interface event_counter_sampler_if
  import perf_counter_pkg::*;
#(
  parameter int NUM_EVENTS    = DEF_NUM_EVENTS,
  parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH
);

  logic                                out_valid;
  logic                                out_ready;
  logic [NUM_EVENTS*COUNTER_WIDTH-1:0] snapshot_counters;
  logic [NUM_EVENTS-1:0]               snapshot_overflow;
  logic                                snapshot_lost;

  modport master (
    output out_valid,
    output snapshot_counters,
    output snapshot_overflow,
    output snapshot_lost,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  snapshot_counters,
    input  snapshot_overflow,
    input  snapshot_lost,
    output out_ready
  );

endinterface

// File: rtl/event_counter_cell.sv
// One channel's live counter with wrap/saturate behaviour and overflow flag.
// The post-increment value is exported so a capture can snapshot the count
// including the event of the capture cycle itself.
module event_counter_cell
  import perf_counter_pkg::*;
#(
  parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     inc_i,
  input  logic                     saturate_mode_i,
  input  logic                     clear_i,
  output logic [COUNTER_WIDTH-1:0] count_next_o,
  output logic                     ovf_next_o
);

  logic [COUNTER_WIDTH-1:0] count_q, count_d, count_inc;
  logic                     ovf_q, ovf_d, ovf_inc;

  // Increment with wrap or saturate at all-ones; a capture clears the channel.
  always_comb begin
    count_inc = count_q;
    ovf_inc   = ovf_q;
    if (inc_i) begin
      if (&count_q) begin
        count_inc = saturate_mode_i ? count_q : '0;
        ovf_inc   = 1'b1;
      end else begin
        count_inc = count_q + COUNTER_WIDTH'(1);
      end
    end
    count_d = clear_i ? '0   : count_inc;
    ovf_d   = clear_i ? 1'b0 : ovf_inc;
  end

  assign count_next_o = count_inc;
  assign ovf_next_o   = ovf_inc;

  // Live counter state; reset holds the channel at zero and ignores events.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: rtl/event_counter_sampler.sv
// Per-channel event counters sampled into a held snapshot either at the end
// of a programmable window or on a manual trigger, delivered over a
// valid/ready output with a sticky flag for dropped captures.
module event_counter_sampler
  import perf_counter_pkg::*;
#(
  parameter int NUM_EVENTS    = DEF_NUM_EVENTS,
  parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH,
  parameter int WINDOW_WIDTH  = DEF_WINDOW_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_EVENTS-1:0]   performance_events,
  input  logic [NUM_EVENTS-1:0]   enable_mask,
  input  logic                    saturate_mode,
  input  logic [WINDOW_WIDTH-1:0] window_len,
  input  logic                    trigger,
  event_counter_sampler_if.master out_if
);

  localparam int SNAP_W = NUM_EVENTS * COUNTER_WIDTH;

  logic [SNAP_W-1:0]       live_next;
  logic [NUM_EVENTS-1:0]   live_ovf_next;
  logic [WINDOW_WIDTH-1:0] win_q, win_d, win_last;
  logic                    window_end, capture, load_snap, drop_snap;
  out_state_e              state_q, state_d;
  logic [SNAP_W-1:0]       snap_cnt_q, snap_cnt_d;
  logic [NUM_EVENTS-1:0]   snap_ovf_q, snap_ovf_d;
  logic                    lost_q, lost_d;

  // A zero window length never matches, which disables auto-capture.
  assign win_last   = window_len - WINDOW_WIDTH'(1);
  assign window_end = (window_len != '0) && (win_q == win_last);
  assign capture    = trigger | window_end;

  for (genvar i = 0; i < NUM_EVENTS; i++) begin : g_cell
    event_counter_cell #(
      .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_cell (
      .clk             (clk),
      .rst_n           (rst_n),
      .inc_i           (performance_events[i] & enable_mask[i]),
      .saturate_mode_i (saturate_mode),
      .clear_i         (capture),
      .count_next_o    (live_next[i*COUNTER_WIDTH +: COUNTER_WIDTH]),
      .ovf_next_o      (live_ovf_next[i])
    );
  end

  // Window counter: restart on capture, or silently when window_len shrank below it.
  always_comb begin
    win_d = win_q + WINDOW_WIDTH'(1);
    if (capture || (win_q >= window_len)) begin
      win_d = '0;
    end
  end

  // Output FSM and snapshot holding register next-state.
  always_comb begin
    load_snap  = capture && ((state_q == OUT_EMPTY) || out_if.out_ready);
    drop_snap  = capture && (state_q == OUT_FULL) && !out_if.out_ready;
    state_d    = state_q;
    snap_cnt_d = snap_cnt_q;
    snap_ovf_d = snap_ovf_q;
    lost_d     = lost_q | drop_snap;
    if (load_snap) begin
      state_d    = OUT_FULL;
      snap_cnt_d = live_next;
      snap_ovf_d = live_ovf_next;
    end else if ((state_q == OUT_FULL) && out_if.out_ready) begin
      state_d = OUT_EMPTY;
    end
  end

  // State registers; reset discards any pending snapshot and the lost flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_q      <= '0;
      state_q    <= OUT_EMPTY;
      snap_cnt_q <= '0;
      snap_ovf_q <= '0;
      lost_q     <= 1'b0;
    end else begin
      win_q      <= win_d;
      state_q    <= state_d;
      snap_cnt_q <= snap_cnt_d;
      snap_ovf_q <= snap_ovf_d;
      lost_q     <= lost_d;
    end
  end

  assign out_if.out_valid         = (state_q == OUT_FULL);
  assign out_if.snapshot_counters = snap_cnt_q;
  assign out_if.snapshot_overflow = snap_ovf_q;
  assign out_if.snapshot_lost     = lost_q;

endmodule

// File: tb/tb_event_counter_sampler.sv
// Directed bench for event_counter_sampler with 8 channels of 3-bit counters.
module tb_event_counter_sampler;

  localparam int NE = 8;
  localparam int CW = 3;
  localparam int WW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NE-1:0] performance_events = '0;
  logic [NE-1:0] enable_mask = '0;
  logic          saturate_mode = 1'b0;
  logic [WW-1:0] window_len = '0;
  logic          trigger = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  event_counter_sampler_if #(.NUM_EVENTS(NE), .COUNTER_WIDTH(CW)) out_if ();

  event_counter_sampler #(
    .NUM_EVENTS    (NE),
    .COUNTER_WIDTH (CW),
    .WINDOW_WIDTH  (WW)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .performance_events (performance_events),
    .enable_mask        (enable_mask),
    .saturate_mode      (saturate_mode),
    .window_len         (window_len),
    .trigger            (trigger),
    .out_if             (out_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rn;
    logic [NE-1:0] ev;
    logic [NE-1:0] mask;
    logic          sat;
    logic          trg;
    logic          rdy;
    logic          e_valid;
    logic          e_cs;
    logic [23:0]   e_cnt;
    logic [7:0]    e_ovf;
    logic          e_lost;
    string         nm;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rn, input logic [7:0] ev, input logic [7:0] mask,
                              input logic sat, input logic trg, input logic rdy,
                              input logic e_valid, input logic e_cs, input logic [23:0] e_cnt,
                              input logic [7:0] e_ovf, input logic e_lost, input string nm);
    vec_t v;
    v.rn = rn; v.ev = ev; v.mask = mask; v.sat = sat; v.trg = trg; v.rdy = rdy;
    v.e_valid = e_valid; v.e_cs = e_cs; v.e_cnt = e_cnt; v.e_ovf = e_ovf;
    v.e_lost = e_lost; v.nm = nm;
    return v;
  endfunction

  task automatic drive(input logic rn, input logic [7:0] ev, input logic [7:0] mask,
                       input logic sat, input logic [7:0] wl, input logic trg, input logic rdy);
    rst_n              = rn;
    performance_events = ev;
    enable_mask        = mask;
    saturate_mode      = sat;
    window_len         = wl;
    trigger            = trg;
    out_if.out_ready   = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic e_valid, input logic e_cs,
                       input logic [23:0] e_cnt, input logic [7:0] e_ovf, input logic e_lost);
    n_cmp++;
    if (out_if.out_valid !== e_valid) begin
      n_bad++;
      $display("FAIL %s out_valid got %0b want %0b", nm, out_if.out_valid, e_valid);
    end
    n_cmp++;
    if (out_if.snapshot_lost !== e_lost) begin
      n_bad++;
      $display("FAIL %s snapshot_lost got %0b want %0b", nm, out_if.snapshot_lost, e_lost);
    end
    if (e_cs) begin
      n_cmp++;
      if (out_if.snapshot_counters !== e_cnt) begin
        n_bad++;
        $display("FAIL %s snapshot_counters got %06h want %06h", nm, out_if.snapshot_counters, e_cnt);
      end
      n_cmp++;
      if (out_if.snapshot_overflow !== e_ovf) begin
        n_bad++;
        $display("FAIL %s snapshot_overflow got %02h want %02h", nm, out_if.snapshot_overflow, e_ovf);
      end
    end
  endtask

  initial begin
    out_if.out_ready = 1'b0;

    // Reset with events present: nothing counted, outputs zero.
    for (int i = 0; i < 2; i++) tbl.push_back(mk(0, 8'hFF, 8'hFF, 0, 0, 0, 0, 1, 24'h0, 8'h00, 0, "reset"));
    // Wrap: 9 events on ch0, trigger on the 9th -> 7 wraps to 0, then 1 with overflow.
    for (int i = 0; i < 8; i++) tbl.push_back(mk(1, 8'h01, 8'hFF, 0, 0, 0, 0, 0, 24'h0, 8'h00, 0, "wrap_pre"));
    tbl.push_back(mk(1, 8'h01, 8'hFF, 0, 1, 0, 1, 1, 24'h000001, 8'h01, 0, "wrap_cap"));
    tbl.push_back(mk(1, 8'h00, 8'hFF, 0, 0, 0, 1, 1, 24'h000001, 8'h01, 0, "wrap_hold"));
    tbl.push_back(mk(1, 8'h00, 8'hFF, 0, 0, 1, 0, 0, 24'h0, 8'h00, 0, "wrap_pop"));
    // Saturate: same stimulus holds at 7 with overflow.
    for (int i = 0; i < 8; i++) tbl.push_back(mk(1, 8'h01, 8'hFF, 1, 0, 0, 0, 0, 24'h0, 8'h00, 0, "sat_pre"));
    tbl.push_back(mk(1, 8'h01, 8'hFF, 1, 1, 0, 1, 1, 24'h000007, 8'h01, 0, "sat_cap"));
    tbl.push_back(mk(1, 8'h00, 8'hFF, 1, 0, 1, 0, 0, 24'h0, 8'h00, 0, "sat_pop"));
    // Mask: ch0..ch2 active, ch2 disabled -> ch0=3, ch1=3, ch2=0.
    for (int i = 0; i < 2; i++) tbl.push_back(mk(1, 8'h07, 8'hFB, 0, 0, 0, 0, 0, 24'h0, 8'h00, 0, "mask_pre"));
    tbl.push_back(mk(1, 8'h07, 8'hFB, 0, 1, 0, 1, 1, 24'h00001B, 8'h00, 0, "mask_cap"));
    tbl.push_back(mk(1, 8'h00, 8'hFB, 0, 0, 1, 0, 0, 24'h0, 8'h00, 0, "mask_pop"));

    foreach (tbl[i]) begin
      drive(tbl[i].rn, tbl[i].ev, tbl[i].mask, tbl[i].sat, 8'd0, tbl[i].trg, tbl[i].rdy);
      check(tbl[i].nm, tbl[i].e_valid, tbl[i].e_cs, tbl[i].e_cnt, tbl[i].e_ovf, tbl[i].e_lost);
    end

    // Window of 4 with ch1 and masked ch2 always high: pulse every 4 cycles, ch1=4.
    for (int k = 0; k < 12; k++) begin
      drive(1, 8'h06, 8'hFB, 0, 8'd4, 0, 1);
      check($sformatf("win4_k%0d", k), (k % 4) == 3, (k % 4) == 3, 24'h000020, 8'h00, 0);
    end

    // Consumer stalls across the next window end: held snapshot survives, lost sets.
    for (int k = 12; k < 16; k++) begin
      drive(1, 8'h03, 8'hFB, 0, 8'd4, 0, 0);
      check($sformatf("stall_k%0d", k), 1, 1, 24'h000020, 8'h00, k == 15);
    end
    drive(1, 8'h00, 8'hFB, 0, 8'd4, 0, 1);
    check("stall_pop", 0, 0, 24'h0, 8'h00, 1);
    // Dropped capture still cleared the live counters.
    drive(1, 8'h00, 8'hFB, 0, 8'd4, 1, 1);
    check("drop_cleared", 1, 1, 24'h000000, 8'h00, 1);

    // Trigger coinciding with window end: one capture, window restarts once.
    drive(1, 8'h00, 8'hFB, 0, 8'd4, 0, 1);
    check("coinc_pop", 0, 0, 24'h0, 8'h00, 1);
    drive(1, 8'h01, 8'hFB, 0, 8'd4, 0, 1);
    check("coinc_w1", 0, 0, 24'h0, 8'h00, 1);
    drive(1, 8'h01, 8'hFB, 0, 8'd4, 0, 1);
    check("coinc_w2", 0, 0, 24'h0, 8'h00, 1);
    drive(1, 8'h01, 8'hFB, 0, 8'd4, 1, 1);
    check("coinc_cap", 1, 1, 24'h000003, 8'h00, 1);
    for (int k = 22; k < 26; k++) begin
      drive(1, 8'h00, 8'hFB, 0, 8'd4, 0, 1);
      check($sformatf("coinc_next_k%0d", k), k == 25, k == 25, 24'h000000, 8'h00, 1);
    end

    // Shrinking window_len below the window counter wraps without a capture.
    drive(1, 8'h01, 8'hFB, 0, 8'd4, 0, 1);
    check("shrink_k26", 0, 0, 24'h0, 8'h00, 1);
    drive(1, 8'h01, 8'hFB, 0, 8'd4, 0, 1);
    check("shrink_k27", 0, 0, 24'h0, 8'h00, 1);
    drive(1, 8'h01, 8'hFB, 0, 8'd2, 0, 1);
    check("shrink_wrap", 0, 0, 24'h0, 8'h00, 1);
    drive(1, 8'h01, 8'hFB, 0, 8'd2, 0, 1);
    check("shrink_k29", 0, 0, 24'h0, 8'h00, 1);
    drive(1, 8'h01, 8'hFB, 0, 8'd2, 0, 0);
    check("shrink_cap", 1, 1, 24'h000005, 8'h00, 1);

    // One-cycle reset while FULL discards everything; events during reset ignored.
    drive(0, 8'hFF, 8'hFF, 0, 8'd2, 0, 0);
    check("rst_full", 0, 1, 24'h000000, 8'h00, 0);
    drive(1, 8'h00, 8'hFF, 0, 8'd0, 1, 0);
    check("rst_after_cap", 1, 1, 24'h000000, 8'h00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
